// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types, channel slices and helpers for the video decimator
package video_pkg;

    // Channel positions in the receiver word, in units of CH_W: R on top, then B, then G.
    localparam int R_HI = 3;
    localparam int R_LO = 2;
    localparam int B_HI = 2;
    localparam int B_LO = 1;
    localparam int G_HI = 1;
    localparam int G_LO = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/hbox_accum.sv
// rtl/hbox_accum.sv - per-channel horizontal box accumulator producing the truncated group mean
module hbox_accum
    import video_pkg::*;
#(
    parameter int CH_W  = 8,
    parameter int H_DEC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            add,
    input  logic [CH_W-1:0] pixel,
    output logic [CH_W-1:0] mean
);
    localparam int SH = clog2(H_DEC);
    localparam int AW = CH_W + SH;

    logic [AW-1:0] acc;
    logic [AW-1:0] sum;

    // The sum includes the current pixel so the mean is ready in the same cycle as the last one.
    assign sum  = (load ? '0 : acc) + AW'(pixel);
    assign mean = sum[AW-1:SH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (load) begin
            acc <= AW'(pixel);
        end else if (add) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/video_decimator.sv
// rtl/video_decimator.sv - armed integer-factor video decimator with linear frame-buffer write port
module video_decimator
    import video_pkg::*;
#(
    parameter int CH_W       = 8,
    parameter int H_DEC      = 2,
    parameter int V_DEC      = 2,
    parameter bit AVG_EN     = 1'b0,
    parameter bit CONTINUOUS = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int ADDR_W     = 24,
    parameter int DEPTH      = 307200
) (
    input  logic              pclk,
    input  logic              rstb,
    input  logic              i_arm,
    input  logic              i_stop,
    input  logic [3*CH_W-1:0] i_data,
    input  logic              i_vde,
    input  logic              i_hsync,
    input  logic              i_vsync,
    output logic              o_ena,
    output logic [ADDR_W-1:0] o_addr,
    output logic [CH_W-1:0]   o_r,
    output logic [CH_W-1:0]   o_g,
    output logic [CH_W-1:0]   o_b,
    output logic              o_frame_start,
    output logic              o_frame_done,
    output logic              o_overflow,
    output logic              o_busy
);
    localparam int SH = clog2(H_DEC);
    localparam int CW = (SH > 0) ? SH : 1;
    localparam int RW = (clog2(V_DEC) > 0) ? clog2(V_DEC) : 1;

    logic [3*CH_W-1:0] data_q;
    logic              vde_q, vde_d, vs_q, vs_d, hsync_unused_q;

    always_ff @(posedge pclk or posedge rstb) begin
        if (rstb) begin
            data_q         <= '0;
            vde_q          <= 1'b0;
            vde_d          <= 1'b0;
            vs_q           <= 1'b0;
            vs_d           <= 1'b0;
            hsync_unused_q <= 1'b0;
        end else begin
            data_q         <= i_data;
            vde_q          <= i_vde;
            vde_d          <= vde_q;
            vs_q           <= i_vsync;
            vs_d           <= vs_q;
            hsync_unused_q <= i_hsync;
        end
    end

    logic boundary, vde_fall;
    assign boundary = (vs_q == VS_POL) && (vs_d != VS_POL);
    assign vde_fall = vde_d && !vde_q;

    state_t state, state_nxt;
    logic   start_nxt, done_nxt, stop_seen;

    always_ff @(posedge pclk or posedge rstb) begin
        if (rstb) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (i_arm && !i_stop) state_nxt = WAIT_VS;
            end
            WAIT_VS: begin
                if (i_stop) begin
                    state_nxt = IDLE;
                end else if (boundary) begin
                    state_nxt = CAPTURE;
                    start_nxt = 1'b1;
                end
            end
            CAPTURE: begin
                if (boundary) begin
                    done_nxt = 1'b1;
                    if (stop_seen || i_stop || !CONTINUOUS) state_nxt = IDLE;
                    else                                    start_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A stop during capture is deferred so the current frame still completes.
    always_ff @(posedge pclk or posedge rstb) begin
        if (rstb)                              stop_seen <= 1'b0;
        else if (state != CAPTURE || boundary) stop_seen <= 1'b0;
        else if (i_stop)                       stop_seen <= 1'b1;
    end

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          col_last, col_first, emit;

    assign col_last  = (col == CW'(H_DEC - 1));
    assign col_first = (col == '0);
    assign emit      = (state == CAPTURE) && vde_q && !boundary && (row == '0) && col_last;

    always_ff @(posedge pclk or posedge rstb) begin
        if (rstb) begin
            col <= '0;
            row <= '0;
        end else if (start_nxt) begin
            col <= '0;
            row <= '0;
        end else if (vde_fall) begin
            col <= '0;
            row <= (row == RW'(V_DEC - 1)) ? '0 : row + 1'b1;
        end else if (vde_q) begin
            col <= col_last ? '0 : col + 1'b1;
        end
    end

    logic [CH_W-1:0] r_in, g_in, b_in, r_avg, g_avg, b_avg;
    assign r_in = data_q[R_HI*CH_W-1:R_LO*CH_W];
    assign b_in = data_q[B_HI*CH_W-1:B_LO*CH_W];
    assign g_in = data_q[G_HI*CH_W-1:G_LO*CH_W];

    hbox_accum #(.CH_W(CH_W), .H_DEC(H_DEC)) u_acc_r (
        .clk(pclk), .rst(rstb), .load(vde_q && col_first), .add(vde_q && !col_first),
        .pixel(r_in), .mean(r_avg)
    );
    hbox_accum #(.CH_W(CH_W), .H_DEC(H_DEC)) u_acc_g (
        .clk(pclk), .rst(rstb), .load(vde_q && col_first), .add(vde_q && !col_first),
        .pixel(g_in), .mean(g_avg)
    );
    hbox_accum #(.CH_W(CH_W), .H_DEC(H_DEC)) u_acc_b (
        .clk(pclk), .rst(rstb), .load(vde_q && col_first), .add(vde_q && !col_first),
        .pixel(b_in), .mean(b_avg)
    );

    // One extra bit lets the address saturate at DEPTH without wrapping.
    logic [ADDR_W:0] addr;

    always_ff @(posedge pclk or posedge rstb) begin
        if (rstb) begin
            addr          <= '0;
            o_ena         <= 1'b0;
            o_addr        <= '0;
            o_r           <= '0;
            o_g           <= '0;
            o_b           <= '0;
            o_frame_start <= 1'b0;
            o_frame_done  <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            o_ena         <= 1'b0;
            o_frame_start <= start_nxt;
            o_frame_done  <= done_nxt;
            if (start_nxt) begin
                addr       <= '0;
                o_overflow <= 1'b0;
            end else if (emit) begin
                if (addr == (ADDR_W + 1)'(DEPTH)) begin
                    o_overflow <= 1'b1;
                end else begin
                    o_ena  <= 1'b1;
                    o_addr <= addr[ADDR_W-1:0];
                    addr   <= addr + 1'b1;
                    o_r    <= AVG_EN ? r_avg : r_in;
                    o_g    <= AVG_EN ? g_avg : g_in;
                    o_b    <= AVG_EN ? b_avg : b_in;
                end
            end
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_video_decimator.sv
// tb/tb_video_decimator.sv - randomized scoreboard bench for two video_decimator configurations
module tb_video_decimator;
    localparam int CH_W    = 8;
    localparam int C_H     = 2;
    localparam int C_V     = 2;
    localparam int C_AVG   = 1;
    localparam int C_DEPTH = 20;
    localparam int C_AW    = 8;
    localparam int S_H     = 1;
    localparam int S_V     = 3;
    localparam int S_AVG   = 0;
    localparam int S_DEPTH = 1000;
    localparam int S_AW    = 10;
    localparam int MAXW    = 16;
    localparam int MAXH    = 16;

    logic pclk = 1'b0, rstb = 1'b1, i_arm = 1'b0, i_stop = 1'b0;
    logic i_vde = 1'b0, i_hsync = 1'b0, i_vsync = 1'b0;
    logic [3*CH_W-1:0] i_data = '0;
    logic vsync_n;
    assign vsync_n = ~i_vsync;

    logic            c_ena, c_fs, c_fd, c_ovf, c_busy;
    logic [C_AW-1:0] c_addr;
    logic [7:0]      c_r, c_g, c_b;
    logic            s_ena, s_fs, s_fd, s_ovf, s_busy;
    logic [S_AW-1:0] s_addr;
    logic [7:0]      s_r, s_g, s_b;

    logic [C_AW+28:0] c_outs;
    logic [S_AW+28:0] s_outs;
    assign c_outs = {c_ena, c_addr, c_r, c_g, c_b, c_fs, c_fd, c_ovf, c_busy};
    assign s_outs = {s_ena, s_addr, s_r, s_g, s_b, s_fs, s_fd, s_ovf, s_busy};

    video_decimator #(
        .CH_W(CH_W), .H_DEC(C_H), .V_DEC(C_V), .AVG_EN(1'b1), .CONTINUOUS(1'b1),
        .VS_POL(1'b1), .ADDR_W(C_AW), .DEPTH(C_DEPTH)
    ) dut_c (
        .pclk(pclk), .rstb(rstb), .i_arm(i_arm), .i_stop(i_stop), .i_data(i_data),
        .i_vde(i_vde), .i_hsync(i_hsync), .i_vsync(i_vsync), .o_ena(c_ena), .o_addr(c_addr),
        .o_r(c_r), .o_g(c_g), .o_b(c_b), .o_frame_start(c_fs), .o_frame_done(c_fd),
        .o_overflow(c_ovf), .o_busy(c_busy)
    );

    video_decimator #(
        .CH_W(CH_W), .H_DEC(S_H), .V_DEC(S_V), .AVG_EN(1'b0), .CONTINUOUS(1'b0),
        .VS_POL(1'b0), .ADDR_W(S_AW), .DEPTH(S_DEPTH)
    ) dut_s (
        .pclk(pclk), .rstb(rstb), .i_arm(i_arm), .i_stop(i_stop), .i_data(i_data),
        .i_vde(i_vde), .i_hsync(i_hsync), .i_vsync(vsync_n), .o_ena(s_ena), .o_addr(s_addr),
        .o_r(s_r), .o_g(s_g), .o_b(s_b), .o_frame_start(s_fs), .o_frame_done(s_fd),
        .o_overflow(s_ovf), .o_busy(s_busy)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0, n_fail = 0;
    logic [23:0] frame_pix [0:MAXH-1][0:MAXW-1];
    logic [39:0] exp_c[$], exp_s[$], got_c[$], got_s[$];
    logic        exp_ovf_c;
    int          start_c = 0, done_c = 0, start_s = 0, done_s = 0;
    logic        ovf_at_start_c = 1'b0;

    always @(negedge pclk) begin
        if (!rstb) begin
            if (c_ena) got_c.push_back({16'(c_addr), c_r, c_g, c_b});
            if (s_ena) got_s.push_back({16'(s_addr), s_r, s_g, s_b});
            if (c_fs) begin
                start_c++;
                ovf_at_start_c = c_ovf;
            end
            if (c_fd) done_c++;
            if (s_fs) start_s++;
            if (s_fd) done_s++;
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic fill_random(input int w, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) frame_pix[r][c] = 24'($urandom);
    endtask

    // Reference: keep every V-th line, reduce each full group of H pixels, number outputs until DEPTH.
    task automatic build_expect(input bit sel_c, input int w, input int h);
        int hd, vd, depth, n, sr, sg, sb;
        bit avg;
        logic [23:0] p;
        logic [39:0] e;
        hd    = sel_c ? C_H : S_H;
        vd    = sel_c ? C_V : S_V;
        avg   = (sel_c ? C_AVG : S_AVG) != 0;
        depth = sel_c ? C_DEPTH : S_DEPTH;
        n     = 0;
        if (sel_c) begin
            exp_c.delete();
            exp_ovf_c = 1'b0;
        end else begin
            exp_s.delete();
        end
        for (int r = 0; r < h; r++) begin
            if (r % vd != 0) continue;
            for (int g = 0; g + hd <= w; g += hd) begin
                sr = 0; sg = 0; sb = 0; p = '0;
                for (int k = 0; k < hd; k++) begin
                    p = frame_pix[r][g + k];
                    sr += int'(p[23:16]);
                    sg += int'(p[7:0]);
                    sb += int'(p[15:8]);
                end
                if (avg) e = {16'(n), 8'(sr / hd), 8'(sg / hd), 8'(sb / hd)};
                else     e = {16'(n), p[23:16], p[7:0], p[15:8]};
                if (n < depth) begin
                    if (sel_c) exp_c.push_back(e);
                    else       exp_s.push_back(e);
                end else if (sel_c) begin
                    exp_ovf_c = 1'b1;
                end
                n++;
            end
        end
    endtask

    task automatic drive_vsync();
        i_vsync = 1'b1;
        repeat (3) tick();
        i_vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic drive_line(input int r, input int w);
        for (int c = 0; c < w; c++) begin
            i_vde  = 1'b1;
            i_data = frame_pix[r][c];
            tick();
        end
        i_vde   = 1'b0;
        i_data  = '0;
        i_hsync = 1'b1;
        repeat (2) tick();
        i_hsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic drive_frame(input int w, input int h, input int stop_line);
        drive_vsync();
        for (int r = 0; r < h; r++) begin
            drive_line(r, w);
            if (r == stop_line) begin
                i_stop = 1'b1;
                tick();
                i_stop = 1'b0;
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rstb = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (c_outs !== '0) begin n_fail++; $display("FAIL reset_c: got %h required 0", c_outs); end
        n_cmp++;
        if (s_outs !== '0) begin n_fail++; $display("FAIL reset_s: got %h required 0", s_outs); end
        rstb = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({c_outs, s_outs} !== '0) begin n_fail++; $display("FAIL reset_release: got %h required 0", {c_outs, s_outs}); end
    endtask

    task automatic test_continuous();
        int sc, ss, dc, ds;
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        n_cmp++;
        if ({c_busy, s_busy} !== 2'b11) begin n_fail++; $display("FAIL arm_busy: got %b required 11", {c_busy, s_busy}); end

        fill_random(8, 6);
        build_expect(1'b1, 8, 6);
        build_expect(1'b0, 8, 6);
        got_c.delete(); got_s.delete();
        sc = start_c; ss = start_s; dc = done_c; ds = done_s;
        drive_frame(8, 6, -1);
        n_cmp++;
        if (got_c.size() !== exp_c.size()) begin n_fail++; $display("FAIL frame_a_c_count: got %0d required %0d", got_c.size(), exp_c.size()); end
        for (int i = 0; i < exp_c.size() && i < got_c.size(); i++) begin
            n_cmp++;
            if (got_c[i] !== exp_c[i]) begin n_fail++; $display("FAIL frame_a_c_pix[%0d]: got %h required %h", i, got_c[i], exp_c[i]); end
        end
        n_cmp++;
        if (got_s.size() !== exp_s.size()) begin n_fail++; $display("FAIL frame_a_s_count: got %0d required %0d", got_s.size(), exp_s.size()); end
        for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) begin
            n_cmp++;
            if (got_s[i] !== exp_s[i]) begin n_fail++; $display("FAIL frame_a_s_pix[%0d]: got %h required %h", i, got_s[i], exp_s[i]); end
        end
        n_cmp++;
        if ({start_c - sc, start_s - ss, done_c - dc, done_s - ds} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL frame_a_pulses: got start %0d/%0d done %0d/%0d required 1/1 0/0", start_c - sc, start_s - ss, done_c - dc, done_s - ds);
        end

        fill_random(8, 6);
        build_expect(1'b1, 8, 6);
        got_c.delete(); got_s.delete();
        sc = start_c; ss = start_s; dc = done_c; ds = done_s;
        drive_frame(8, 6, -1);
        n_cmp++;
        if (got_c.size() !== exp_c.size()) begin n_fail++; $display("FAIL frame_b_c_count: got %0d required %0d", got_c.size(), exp_c.size()); end
        for (int i = 0; i < exp_c.size() && i < got_c.size(); i++) begin
            n_cmp++;
            if (got_c[i] !== exp_c[i]) begin n_fail++; $display("FAIL frame_b_c_pix[%0d]: got %h required %h", i, got_c[i], exp_c[i]); end
        end
        n_cmp++;
        if (got_s.size() !== 0) begin n_fail++; $display("FAIL single_shot_idle_count: got %0d required 0", got_s.size()); end
        n_cmp++;
        if ({start_c - sc, start_s - ss, done_c - dc, done_s - ds} !== {32'd1, 32'd0, 32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL frame_b_pulses: got start %0d/%0d done %0d/%0d required 1/0 1/1", start_c - sc, start_s - ss, done_c - dc, done_s - ds);
        end
        n_cmp++;
        if ({c_busy, s_busy, c_ovf} !== 3'b100) begin n_fail++; $display("FAIL frame_b_busy_ovf: got %b required 100", {c_busy, s_busy, c_ovf}); end
    endtask

    task automatic test_avg_odd_line();
        logic [39:0] e;
        fill_random(5, 2);
        frame_pix[0][0][23:16] = 8'd10;
        frame_pix[0][1][23:16] = 8'd21;
        frame_pix[0][2][23:16] = 8'd255;
        frame_pix[0][3][23:16] = 8'd0;
        build_expect(1'b1, 5, 2);
        got_c.delete();
        drive_frame(5, 2, -1);
        n_cmp++;
        if (got_c.size() !== 2) begin n_fail++; $display("FAIL odd_line_count: got %0d required 2", got_c.size()); end
        if (got_c.size() >= 2) begin
            e = got_c[0];
            n_cmp++;
            if (e[23:16] !== 8'd15) begin n_fail++; $display("FAIL avg_r0: got %0d required 15", e[23:16]); end
            e = got_c[1];
            n_cmp++;
            if (e[23:16] !== 8'd127) begin n_fail++; $display("FAIL avg_r1: got %0d required 127", e[23:16]); end
        end
        for (int i = 0; i < exp_c.size() && i < got_c.size(); i++) begin
            n_cmp++;
            if (got_c[i] !== exp_c[i]) begin n_fail++; $display("FAIL odd_line_pix[%0d]: got %h required %h", i, got_c[i], exp_c[i]); end
        end
    endtask

    task automatic test_overflow();
        fill_random(8, 12);
        build_expect(1'b1, 8, 12);
        got_c.delete();
        drive_frame(8, 12, -1);
        n_cmp++;
        if (got_c.size() !== C_DEPTH) begin n_fail++; $display("FAIL ovf_count: got %0d required %0d", got_c.size(), C_DEPTH); end
        for (int i = 0; i < exp_c.size() && i < got_c.size(); i++) begin
            n_cmp++;
            if (got_c[i] !== exp_c[i]) begin n_fail++; $display("FAIL ovf_pix[%0d]: got %h required %h", i, got_c[i], exp_c[i]); end
        end
        n_cmp++;
        if (c_ovf !== exp_ovf_c) begin n_fail++; $display("FAIL ovf_flag: got %b required %b", c_ovf, exp_ovf_c); end
    endtask

    task automatic test_stop();
        int sc, dc;
        fill_random(8, 4);
        build_expect(1'b1, 8, 4);
        got_c.delete(); got_s.delete();
        ovf_at_start_c = 1'bx;
        drive_frame(8, 4, 1);
        n_cmp++;
        if (ovf_at_start_c !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_at_start: got %b required 0", ovf_at_start_c); end
        n_cmp++;
        if (got_c.size() !== exp_c.size()) begin n_fail++; $display("FAIL stop_frame_count: got %0d required %0d", got_c.size(), exp_c.size()); end
        for (int i = 0; i < exp_c.size() && i < got_c.size(); i++) begin
            n_cmp++;
            if (got_c[i] !== exp_c[i]) begin n_fail++; $display("FAIL stop_frame_pix[%0d]: got %h required %h", i, got_c[i], exp_c[i]); end
        end
        fill_random(8, 2);
        got_c.delete();
        sc = start_c; dc = done_c;
        drive_frame(8, 2, -1);
        n_cmp++;
        if ({start_c - sc, done_c - dc} !== {32'd0, 32'd1}) begin
            n_fail++;
            $display("FAIL stop_pulses: got start %0d done %0d required 0 1", start_c - sc, done_c - dc);
        end
        n_cmp++;
        if ({c_busy, 16'(got_c.size()), 16'(got_s.size())} !== 33'd0) begin
            n_fail++;
            $display("FAIL stop_idle: got busy %b outputs %0d/%0d required 0 0/0", c_busy, got_c.size(), got_s.size());
        end
    endtask

    task automatic test_reset_mid();
        int sc, ss;
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        fill_random(8, 4);
        drive_vsync();
        drive_line(0, 8);
        for (int c = 0; c < 4; c++) begin
            i_vde  = 1'b1;
            i_data = frame_pix[1][c];
            tick();
        end
        n_cmp++;
        if ({c_busy, s_busy} !== 2'b11) begin n_fail++; $display("FAIL pre_reset_busy: got %b required 11", {c_busy, s_busy}); end
        rstb = 1'b1;
        #1;
        n_cmp++;
        if ({c_outs, s_outs} !== '0) begin n_fail++; $display("FAIL mid_reset_outputs: got %h required 0", {c_outs, s_outs}); end
        tick();
        rstb   = 1'b0;
        i_vde  = 1'b0;
        i_data = '0;
        repeat (6) tick();

        fill_random(8, 4);
        got_c.delete(); got_s.delete();
        sc = start_c; ss = start_s;
        drive_frame(8, 4, -1);
        n_cmp++;
        if ({16'(got_c.size()), 16'(got_s.size()), 16'(start_c - sc), 16'(start_s - ss)} !== 64'd0) begin
            n_fail++;
            $display("FAIL unarmed_after_reset: got outputs %0d/%0d starts %0d/%0d required all 0", got_c.size(), got_s.size(), start_c - sc, start_s - ss);
        end

        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        fill_random(8, 4);
        build_expect(1'b1, 8, 4);
        build_expect(1'b0, 8, 4);
        got_c.delete(); got_s.delete();
        drive_frame(8, 4, -1);
        n_cmp++;
        if ({16'(got_c.size()), 16'(got_s.size())} !== {16'(exp_c.size()), 16'(exp_s.size())}) begin
            n_fail++;
            $display("FAIL rearm_count: got %0d/%0d required %0d/%0d", got_c.size(), got_s.size(), exp_c.size(), exp_s.size());
        end
        for (int i = 0; i < exp_c.size() && i < got_c.size(); i++) begin
            n_cmp++;
            if (got_c[i] !== exp_c[i]) begin n_fail++; $display("FAIL rearm_c_pix[%0d]: got %h required %h", i, got_c[i], exp_c[i]); end
        end
        for (int i = 0; i < exp_s.size() && i < got_s.size(); i++) begin
            n_cmp++;
            if (got_s[i] !== exp_s[i]) begin n_fail++; $display("FAIL rearm_s_pix[%0d]: got %h required %h", i, got_s[i], exp_s[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_avg_odd_line();
        test_overflow();
        test_stop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
